// File: rtl/booth4_seq_mult.sv
// Sequential radix-4 Booth multiplier: 16x16 signed -> 32-bit product,
// one Booth digit per cycle, valid/ready handshakes on both sides.
module booth4_seq_mult #(
  parameter bit BACK2BACK = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product_o,
  output logic        busy_o
);

  localparam int unsigned W  = 16;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned EW = W + 2;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] LAST_ITER = '1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [EW-1:0]   a_pos;
  logic [EW-1:0]   a_neg;
  logic [W-1:0]    b_q;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   acc;

  logic [EW-1:0]   a_pos_in;
  logic [EW-1:0]   a_neg_in;
  logic            accept;
  logic [W:0]      b_ext;
  logic [4:0]      sh;
  logic [2:0]      triplet;
  logic [EW-1:0]   pp;
  logic [PW-1:0]   pp_ext;
  logic [PW-1:0]   pp_sh;
  logic [PW-1:0]   acc_nxt;

  // Ready in IDLE; with BACK2BACK also in DONE when the result is being taken
  assign in_ready = (state == IDLE) ||
                    (BACK2BACK && (state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // 18-bit +A / -A; the extra bits keep -(-32768) and +/-2A exact
  assign a_pos_in = {{2{a_i[W-1]}}, a_i};
  assign a_neg_in = ~a_pos_in + EW'(1);

  // Booth-4 digit recode for the current iteration and partial-product alignment
  always_comb begin
    b_ext   = {b_q, 1'b0};
    sh      = {1'b0, cnt, 1'b0};
    triplet = b_ext[sh +: 3];
    pp      = '0;
    case (triplet)
      3'b001, 3'b010: pp = a_pos;
      3'b011:         pp = {a_pos[EW-2:0], 1'b0};
      3'b100:         pp = {a_neg[EW-2:0], 1'b0};
      3'b101, 3'b110: pp = a_neg;
      default:        pp = '0;
    endcase
    pp_ext  = {{(PW-EW){pp[EW-1]}}, pp};
    pp_sh   = pp_ext << sh;
    acc_nxt = acc + pp_sh;
  end

  // Control FSM and datapath registers; acceptance overrides the state step
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      a_pos     <= '0;
      a_neg     <= '0;
      b_q       <= '0;
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      product_o <= '0;
      busy_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_ITER) begin
            state     <= DONE;
            out_valid <= 1'b1;
            product_o <= acc_nxt;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy_o    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        a_pos  <= a_pos_in;
        a_neg  <= a_neg_in;
        b_q    <= b_i;
        cnt    <= '0;
        acc    <= '0;
        state  <= CALC;
        busy_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth4_seq_mult.sv
// Directed and streaming checks for booth4_seq_mult (both BACK2BACK settings).
module tb_booth4_seq_mult;

  localparam int NB = 1000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy_o;
  logic [15:0] a_i, b_i;
  logic [31:0] product_o;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [15:0] a2, b2;
  logic [31:0] product2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;
  vec_t vecs [8];

  always #5 sys_clk = ~sys_clk;

  booth4_seq_mult #(.BACK2BACK(1'b0)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a_i(a_i), .b_i(b_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .product_o(product_o), .busy_o(busy_o)
  );

  booth4_seq_mult #(.BACK2BACK(1'b1)) dut_b2b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .a_i(a2), .b_i(b2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .product_o(product2), .busy_o(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  task automatic get_op(input int idx, output logic [15:0] a, output logic [15:0] b);
    if (idx < 8) begin
      a = vecs[idx].a;
      b = vecs[idx].b;
    end else begin
      a = 16'($urandom);
      b = 16'($urandom);
    end
  endtask

  // Single operation on the non-back-to-back instance; latency counts the acceptance edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input string name);
    int n;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    in_valid = 1'b1;
    a_i = a;
    b_i = b;
    tick();
    n = 1;
    chk({name, " busy_after_accept"}, 32'(busy_o), 32'd1);
    while (!out_valid && n < 30) begin
      in_valid = 1'($urandom);
      a_i = 16'($urandom);
      b_i = 16'($urandom);
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk({name, " latency"}, 32'(n), 32'd9);
    chk({name, " product"}, product_o, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, " out_valid_after_hs"}, 32'(out_valid), 32'd0);
    chk({name, " in_ready_after_hs"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int acc_n, res_n, cyc, last;
    bit take;
    logic [31:0] q [$];

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[2] = '{16'h8000, 16'h7FFF, 32'hC0008000};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    vecs[4] = '{16'hFFFF, 16'h0001, 32'hFFFFFFFF};
    vecs[5] = '{16'h0000, 16'hFFFF, 32'h00000000};
    vecs[6] = '{16'h0007, 16'hFFF7, 32'hFFFFFFC1};
    vecs[7] = '{16'h04D2, 16'hE9D2, 32'hFF951644};

    sys_rst_n = 1'b0;
    in_valid = 1'b0; a_i = '0; b_i = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; out_ready2 = 1'b0;
    tick();
    tick();
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset product", product_o, 32'd0);
    sys_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // Result held while the consumer stalls; inputs are ignored
    in_valid = 1'b1; a_i = 16'd100; b_i = 16'hFFFD;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    chk("hold latency", 32'(n), 32'd9);
    chk("hold product", product_o, 32'hFFFFFED4);
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      a_i = 16'($urandom);
      b_i = 16'($urandom);
      tick();
      chk($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("hold%0d product", k), product_o, 32'hFFFFFED4);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold release out_valid", 32'(out_valid), 32'd0);
    chk("hold release in_ready", 32'(in_ready), 32'd1);
    chk("hold release busy", 32'(busy_o), 32'd0);
    chk("idle retains product", product_o, 32'hFFFFFED4);

    // Reset in the middle of iteration 4, then accept on the first edge after release
    in_valid = 1'b1; a_i = 16'h1111; b_i = 16'h2222;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("pre-abort busy", 32'(busy_o), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort busy", 32'(busy_o), 32'd0);
    chk("abort product", product_o, 32'd0);
    tick();
    sys_rst_n = 1'b1;
    in_valid = 1'b1; a_i = 16'h0007; b_i = 16'hFFF7;
    tick();
    in_valid = 1'b0;
    chk("post-reset accept", 32'(busy_o), 32'd1);
    n = 1;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    chk("post-reset latency", 32'(n), 32'd9);
    chk("post-reset product", product_o, 32'hFFFFFFC1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Back-to-back streaming: directed vectors first, then random pairs
    acc_n = 0; res_n = 0; cyc = 0; last = -1;
    out_ready2 = 1'b1;
    get_op(0, a2, b2);
    in_valid2 = 1'b1;
    while (res_n < NB && cyc < NB * 9 + 50) begin
      if (out_valid2) begin
        if (q.size() == 0) chk("b2b unexpected result", 32'd0, 32'd1);
        else chk($sformatf("b2b product %0d", res_n), product2, q.pop_front());
        if (last >= 0) chk("b2b interval", 32'(cyc - last), 32'd9);
        last = cyc;
        res_n++;
      end
      take = in_ready2 && in_valid2;
      if (take) begin
        q.push_back(ref_mul(a2, b2));
        acc_n++;
      end
      tick();
      cyc++;
      if (take) begin
        if (acc_n == NB) in_valid2 = 1'b0;
        else get_op(acc_n, a2, b2);
      end
    end
    chk("b2b result count", 32'(res_n), 32'(NB));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
